// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, demux FSM states and the
// default SoC memory map.
package axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_FWD  = 2'd1,
      W_RESP = 2'd2,
      W_ERR  = 2'd3
   } w_state_e;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_FWD  = 2'd1,
      R_DATA = 2'd2,
      R_ERR  = 2'd3
   } r_state_e;

   localparam logic [31:0] MAP_RAM_BASE   = 32'h0000_0000;
   localparam logic [31:0] MAP_GPIO_BASE  = 32'h1000_0000;
   localparam logic [31:0] MAP_UART_BASE  = 32'h2000_0000;
   localparam logic [31:0] MAP_SPI_BASE   = 32'h3000_0000;
   localparam logic [31:0] MAP_I2C_BASE   = 32'h4000_0000;
   localparam logic [31:0] MAP_TIMER_BASE = 32'h5000_0000;
   localparam logic [31:0] MAP_MASK_4K    = 32'hFFFF_F000;

   localparam int unsigned MAP_N_SLV = 6;
   localparam logic [MAP_N_SLV*32-1:0] MAP_BASE = {
      MAP_TIMER_BASE, MAP_I2C_BASE, MAP_SPI_BASE,
      MAP_UART_BASE, MAP_GPIO_BASE, MAP_RAM_BASE
   };
   localparam logic [MAP_N_SLV*32-1:0] MAP_MASK = {MAP_N_SLV{MAP_MASK_4K}};

endpackage

// File: rtl/axil_demux_n_if.sv
// Upstream AXI4-Lite port plus N flattened downstream ports of the demux.
interface axil_demux_n_if
   import axil_pkg::*;
#(
   parameter int unsigned N_SLV  = MAP_N_SLV,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned STRB_W = DATA_W / 8;

   logic [ADDR_W-1:0]        s_awaddr;
   logic                     s_awvalid, s_awready;
   logic [DATA_W-1:0]        s_wdata;
   logic [STRB_W-1:0]        s_wstrb;
   logic                     s_wvalid, s_wready;
   logic [1:0]               s_bresp;
   logic                     s_bvalid, s_bready;
   logic [ADDR_W-1:0]        s_araddr;
   logic                     s_arvalid, s_arready;
   logic [DATA_W-1:0]        s_rdata;
   logic [1:0]               s_rresp;
   logic                     s_rvalid, s_rready;

   logic [N_SLV*ADDR_W-1:0]  m_awaddr;
   logic [N_SLV-1:0]         m_awvalid, m_awready;
   logic [N_SLV*DATA_W-1:0]  m_wdata;
   logic [N_SLV*STRB_W-1:0]  m_wstrb;
   logic [N_SLV-1:0]         m_wvalid, m_wready;
   logic [N_SLV*2-1:0]       m_bresp;
   logic [N_SLV-1:0]         m_bvalid, m_bready;
   logic [N_SLV*ADDR_W-1:0]  m_araddr;
   logic [N_SLV-1:0]         m_arvalid, m_arready;
   logic [N_SLV*DATA_W-1:0]  m_rdata;
   logic [N_SLV*2-1:0]       m_rresp;
   logic [N_SLV-1:0]         m_rvalid, m_rready;

   modport slave (
      input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
      input  s_araddr, s_arvalid, s_rready,
      output s_awready, s_wready, s_bresp, s_bvalid,
      output s_arready, s_rdata, s_rresp, s_rvalid,
      output m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
      output m_araddr, m_arvalid, m_rready,
      input  m_awready, m_wready, m_bresp, m_bvalid,
      input  m_arready, m_rdata, m_rresp, m_rvalid
   );

   modport master (
      output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
      output s_araddr, s_arvalid, s_rready,
      input  s_awready, s_wready, s_bresp, s_bvalid,
      input  s_arready, s_rdata, s_rresp, s_rvalid,
      input  m_awaddr, m_awvalid, m_wdata, m_wstrb, m_wvalid, m_bready,
      input  m_araddr, m_arvalid, m_rready,
      output m_awready, m_wready, m_bresp, m_bvalid,
      output m_arready, m_rdata, m_rresp, m_rvalid
   );

endinterface

// File: rtl/axil_addr_decode.sv
// BASE/MASK address decoder; lowest matching slot wins, no match flags a miss.
module axil_addr_decode
   import axil_pkg::*;
#(
   parameter int unsigned             N_SLV  = MAP_N_SLV,
   parameter int unsigned             ADDR_W = 32,
   parameter logic [N_SLV*ADDR_W-1:0] BASE   = MAP_BASE,
   parameter logic [N_SLV*ADDR_W-1:0] MASK   = MAP_MASK
) (
   input  logic [ADDR_W-1:0] addr,
   output logic [N_SLV-1:0]  sel,
   output logic              miss
);

   always_comb begin
      sel  = '0;
      miss = 1'b1;
      for (int unsigned i = 0; i < N_SLV; i++) begin
         if (miss && ((addr & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W])) begin
            sel[i] = 1'b1;
            miss   = 1'b0;
         end
      end
   end

endmodule

// File: rtl/axil_demux_n.sv
// 1-to-N AXI4-Lite demultiplexer with independent read/write FSMs, one
// outstanding transaction per direction, and local DECERR for unmapped addresses.
module axil_demux_n
   import axil_pkg::*;
#(
   parameter int unsigned             N_SLV  = MAP_N_SLV,
   parameter int unsigned             ADDR_W = 32,
   parameter int unsigned             DATA_W = 32,
   parameter logic [N_SLV*ADDR_W-1:0] BASE   = MAP_BASE,
   parameter logic [N_SLV*ADDR_W-1:0] MASK   = MAP_MASK
) (
   input  logic          clk,
   input  logic          resetn,
   axil_demux_n_if.slave bus
);

   logic [N_SLV-1:0] aw_sel, ar_sel;
   logic             aw_miss, ar_miss;

   axil_addr_decode #(.N_SLV(N_SLV), .ADDR_W(ADDR_W), .BASE(BASE), .MASK(MASK))
      u_aw_dec (.addr(bus.s_awaddr), .sel(aw_sel), .miss(aw_miss));
   axil_addr_decode #(.N_SLV(N_SLV), .ADDR_W(ADDR_W), .BASE(BASE), .MASK(MASK))
      u_ar_dec (.addr(bus.s_araddr), .sel(ar_sel), .miss(ar_miss));

   logic [N_SLV*ADDR_W-1:0] m_awaddr, m_araddr;

   always_comb begin
      m_awaddr = '0;
      m_araddr = '0;
      for (int unsigned i = 0; i < N_SLV; i++) begin
         m_awaddr[i*ADDR_W +: ADDR_W] = bus.s_awaddr & ~MASK[i*ADDR_W +: ADDR_W];
         m_araddr[i*ADDR_W +: ADDR_W] = bus.s_araddr & ~MASK[i*ADDR_W +: ADDR_W];
      end
   end

   assign bus.m_awaddr = m_awaddr;
   assign bus.m_araddr = m_araddr;
   assign bus.m_wdata  = {N_SLV{bus.s_wdata}};
   assign bus.m_wstrb  = {N_SLV{bus.s_wstrb}};

   w_state_e         w_state_q, w_state_d;
   logic [N_SLV-1:0] wsel_q, wsel_d;
   logic             wmiss_q, wmiss_d, aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic             awready, wready, bvalid;
   logic [1:0]       bresp;
   logic [N_SLV-1:0] m_awvalid, m_wvalid, m_bready;

   always_comb begin
      w_state_d = w_state_q;
      wsel_d    = wsel_q;
      wmiss_d   = wmiss_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      awready   = 1'b0;
      wready    = 1'b0;
      bvalid    = 1'b0;
      bresp     = RESP_OKAY;
      m_awvalid = '0;
      m_wvalid  = '0;
      m_bready  = '0;
      case (w_state_q)
         W_IDLE: begin
            if (bus.s_awvalid) begin
               wsel_d    = aw_sel;
               wmiss_d   = aw_miss;
               w_state_d = W_FWD;
            end
         end
         W_FWD: begin
            // done flags mask each channel so AW and W may complete in any order
            if (wmiss_q) begin
               awready = !aw_done_q;
               wready  = !w_done_q;
            end else begin
               m_awvalid = wsel_q & {N_SLV{bus.s_awvalid & !aw_done_q}};
               m_wvalid  = wsel_q & {N_SLV{bus.s_wvalid & !w_done_q}};
               awready   = |(bus.m_awready & wsel_q) & !aw_done_q;
               wready    = |(bus.m_wready & wsel_q) & !w_done_q;
            end
            aw_done_d = aw_done_q | (bus.s_awvalid & awready);
            w_done_d  = w_done_q | (bus.s_wvalid & wready);
            if (aw_done_d && w_done_d) w_state_d = wmiss_q ? W_ERR : W_RESP;
         end
         W_RESP: begin
            bvalid   = |(bus.m_bvalid & wsel_q);
            m_bready = wsel_q & {N_SLV{bus.s_bready}};
            for (int unsigned i = 0; i < N_SLV; i++)
               if (wsel_q[i]) bresp = bresp | bus.m_bresp[2*i +: 2];
            if (bvalid && bus.s_bready) begin
               w_state_d = W_IDLE;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         W_ERR: begin
            bvalid = 1'b1;
            bresp  = RESP_DECERR;
            if (bus.s_bready) begin
               w_state_d = W_IDLE;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   r_state_e          r_state_q, r_state_d;
   logic [N_SLV-1:0]  rsel_q, rsel_d;
   logic              rmiss_q, rmiss_d;
   logic              arready, rvalid;
   logic [1:0]        rresp;
   logic [DATA_W-1:0] rdata;
   logic [N_SLV-1:0]  m_arvalid, m_rready;

   always_comb begin
      r_state_d = r_state_q;
      rsel_d    = rsel_q;
      rmiss_d   = rmiss_q;
      arready   = 1'b0;
      rvalid    = 1'b0;
      rresp     = RESP_OKAY;
      rdata     = '0;
      m_arvalid = '0;
      m_rready  = '0;
      case (r_state_q)
         R_IDLE: begin
            if (bus.s_arvalid) begin
               rsel_d    = ar_sel;
               rmiss_d   = ar_miss;
               r_state_d = R_FWD;
            end
         end
         R_FWD: begin
            if (rmiss_q) begin
               arready = 1'b1;
            end else begin
               m_arvalid = rsel_q & {N_SLV{bus.s_arvalid}};
               arready   = |(bus.m_arready & rsel_q);
            end
            if (bus.s_arvalid && arready) r_state_d = rmiss_q ? R_ERR : R_DATA;
         end
         R_DATA: begin
            rvalid   = |(bus.m_rvalid & rsel_q);
            m_rready = rsel_q & {N_SLV{bus.s_rready}};
            for (int unsigned i = 0; i < N_SLV; i++) begin
               if (rsel_q[i]) begin
                  rresp = rresp | bus.m_rresp[2*i +: 2];
                  rdata = rdata | bus.m_rdata[i*DATA_W +: DATA_W];
               end
            end
            if (rvalid && bus.s_rready) r_state_d = R_IDLE;
         end
         R_ERR: begin
            rvalid = 1'b1;
            rresp  = RESP_DECERR;
            if (bus.s_rready) r_state_d = R_IDLE;
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         w_state_q <= W_IDLE;
         wsel_q    <= '0;
         wmiss_q   <= 1'b0;
         aw_done_q <= 1'b0;
         w_done_q  <= 1'b0;
         r_state_q <= R_IDLE;
         rsel_q    <= '0;
         rmiss_q   <= 1'b0;
      end else begin
         w_state_q <= w_state_d;
         wsel_q    <= wsel_d;
         wmiss_q   <= wmiss_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         r_state_q <= r_state_d;
         rsel_q    <= rsel_d;
         rmiss_q   <= rmiss_d;
      end
   end

   assign bus.s_awready = awready;
   assign bus.s_wready  = wready;
   assign bus.s_bvalid  = bvalid;
   assign bus.s_bresp   = bresp;
   assign bus.m_awvalid = m_awvalid;
   assign bus.m_wvalid  = m_wvalid;
   assign bus.m_bready  = m_bready;
   assign bus.s_arready = arready;
   assign bus.s_rvalid  = rvalid;
   assign bus.s_rresp   = rresp;
   assign bus.s_rdata   = rdata;
   assign bus.m_arvalid = m_arvalid;
   assign bus.m_rready  = m_rready;

endmodule

// File: tb/tb_axil_demux_n.sv
// Directed bench for axil_demux_n: six slave models behind the default memory map.
module tb_axil_demux_n;
   import axil_pkg::*;

   localparam int unsigned N = 6;

   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   axil_demux_n_if #(.N_SLV(N), .ADDR_W(32), .DATA_W(32)) bus ();

   axil_demux_n #(
      .N_SLV(N), .ADDR_W(32), .DATA_W(32), .BASE(MAP_BASE), .MASK(MAP_MASK)
   ) dut (
      .clk(clk), .resetn(resetn), .bus(bus)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Slave models: always ready; B one cycle after AW+W; R after 10 cycles on slot 0, else 1.
   logic [N-1:0]   aw_got = '0, w_got = '0, bv_q = '0, rv_q = '0, rp_q = '0;
   logic [N-1:0]   rogue_b = '0;
   logic [N*32-1:0] rd_q = '0;
   logic [31:0]    acap [N];
   logic [31:0]    wcap [N];
   logic [3:0]     scap [N];
   int unsigned    rcnt [N];

   assign bus.m_awready = '1;
   assign bus.m_wready  = '1;
   assign bus.m_arready = '1;
   assign bus.m_bvalid  = bv_q | rogue_b;
   assign bus.m_bresp   = 12'h200;
   assign bus.m_rvalid  = rv_q;
   assign bus.m_rdata   = rd_q;
   assign bus.m_rresp   = '0;

   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         if (bus.m_awvalid[i] && bus.m_awready[i]) begin
            aw_got[i] <= 1'b1;
            acap[i]   <= bus.m_awaddr[i*32 +: 32];
         end
         if (bus.m_wvalid[i] && bus.m_wready[i]) begin
            w_got[i] <= 1'b1;
            wcap[i]  <= bus.m_wdata[i*32 +: 32];
            scap[i]  <= bus.m_wstrb[i*4 +: 4];
         end
         if (bv_q[i] && bus.m_bready[i]) begin
            bv_q[i] <= 1'b0;
         end else if (aw_got[i] && w_got[i] && !bv_q[i]) begin
            bv_q[i]   <= 1'b1;
            aw_got[i] <= 1'b0;
            w_got[i]  <= 1'b0;
         end
         if (bus.m_arvalid[i] && bus.m_arready[i]) begin
            rp_q[i]          <= 1'b1;
            rcnt[i]          <= (i == 0) ? 10 : 1;
            rd_q[i*32 +: 32] <= {4'hD, 4'(i), 12'h000, bus.m_araddr[i*32 +: 12]};
         end else if (rp_q[i]) begin
            if (rcnt[i] <= 1) begin
               rp_q[i] <= 1'b0;
               rv_q[i] <= 1'b1;
            end else begin
               rcnt[i] <= rcnt[i] - 1;
            end
         end
         if (rv_q[i] && bus.m_rready[i]) rv_q[i] <= 1'b0;
      end
   end

   logic         mon_clr = 1'b0;
   logic [N-1:0] aw_mask = '0, ar_mask = '0;
   int           b_cnt = 0, r_cnt = 0, cyc = 0, b_t = 0, r_t = 0;
   logic [1:0]   b_resp_cap = '0, r_resp_cap = '0;
   logic [31:0]  r_data_cap = '0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mon_clr) begin
         aw_mask <= '0;
         ar_mask <= '0;
         b_cnt   <= 0;
         r_cnt   <= 0;
      end else begin
         aw_mask <= aw_mask | bus.m_awvalid;
         ar_mask <= ar_mask | bus.m_arvalid;
         if (bus.s_bvalid && bus.s_bready) begin
            b_cnt      <= b_cnt + 1;
            b_t        <= cyc;
            b_resp_cap <= bus.s_bresp;
         end
         if (bus.s_rvalid && bus.s_rready) begin
            r_cnt      <= r_cnt + 1;
            r_t        <= cyc;
            r_data_cap <= bus.s_rdata;
            r_resp_cap <= bus.s_rresp;
         end
      end
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic clr_mon();
      mon_clr = 1'b1;
      tick();
      mon_clr = 1'b0;
   endtask

   task automatic chk_quiet(input string tag);
      chk({tag, "_awready"}, 32'(bus.s_awready), 32'd0);
      chk({tag, "_wready"},  32'(bus.s_wready),  32'd0);
      chk({tag, "_bvalid"},  32'(bus.s_bvalid),  32'd0);
      chk({tag, "_bresp"},   32'(bus.s_bresp),   32'd0);
      chk({tag, "_arready"}, 32'(bus.s_arready), 32'd0);
      chk({tag, "_rvalid"},  32'(bus.s_rvalid),  32'd0);
      chk({tag, "_rresp"},   32'(bus.s_rresp),   32'd0);
      chk({tag, "_rdata"},   bus.s_rdata,        32'd0);
      chk({tag, "_m_valid"}, 32'({bus.m_awvalid, bus.m_wvalid, bus.m_arvalid}), 32'd0);
      chk({tag, "_m_ready"}, 32'({bus.m_bready, bus.m_rready}), 32'd0);
   endtask

   task automatic send_aw_w(input string tag);
      logic aw_hs, w_hs;
      for (int k = 0; k < 20 && (bus.s_awvalid || bus.s_wvalid); k++) begin
         aw_hs = bus.s_awvalid && bus.s_awready;
         w_hs  = bus.s_wvalid && bus.s_wready;
         tick();
         if (aw_hs) bus.s_awvalid = 1'b0;
         if (w_hs)  bus.s_wvalid  = 1'b0;
      end
      chk({tag, "_aw_w_accept"}, 32'({bus.s_awvalid, bus.s_wvalid}), 32'd0);
   endtask

   task automatic wait_b(input string tag);
      for (int k = 0; k < 20; k++) begin
         if (bus.s_bvalid) break;
         tick();
      end
      chk({tag, "_bvalid"}, 32'(bus.s_bvalid), 32'd1);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                           input logic [1:0] resp_exp, input string tag);
      bus.s_awaddr  = a;
      bus.s_awvalid = 1'b1;
      bus.s_wdata   = d;
      bus.s_wstrb   = 4'hF;
      bus.s_wvalid  = 1'b1;
      bus.s_bready  = 1'b1;
      send_aw_w(tag);
      wait_b(tag);
      chk({tag, "_bresp"}, 32'(bus.s_bresp), 32'(resp_exp));
      tick();
      chk({tag, "_bdone"}, 32'(bus.s_bvalid), 32'd0);
   endtask

   task automatic do_read(input logic [31:0] a, input string tag);
      logic hs;
      bus.s_araddr  = a;
      bus.s_arvalid = 1'b1;
      bus.s_rready  = 1'b1;
      for (int k = 0; k < 20 && bus.s_arvalid; k++) begin
         hs = bus.s_arvalid && bus.s_arready;
         tick();
         if (hs) bus.s_arvalid = 1'b0;
      end
      chk({tag, "_ar_accept"}, 32'(bus.s_arvalid), 32'd0);
      for (int k = 0; k < 40; k++) begin
         if (bus.s_rvalid) break;
         tick();
      end
      chk({tag, "_rvalid"}, 32'(bus.s_rvalid), 32'd1);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached with %0d vectors applied", n_vec);
      $fatal(1, "time limit");
   end

   initial begin
      logic       early_wready;
      logic [N-1:0] early_wvalid;

      bus.s_awaddr = '0; bus.s_awvalid = 1'b0; bus.s_wdata = '0; bus.s_wstrb = '0;
      bus.s_wvalid = 1'b0; bus.s_bready = 1'b0; bus.s_araddr = '0; bus.s_arvalid = 1'b0;
      bus.s_rready = 1'b0;
      tick();
      tick();
      chk_quiet("reset");
      resetn = 1'b1;
      tick();

      // Write to UART slot 2
      clr_mon();
      bus.s_awaddr = 32'h2000_0004; bus.s_awvalid = 1'b1;
      bus.s_wdata = 32'hA5A5_A5A5; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
      bus.s_bready = 1'b1;
      #1;
      chk("wr_c0_awvalid", 32'(bus.m_awvalid), 32'd0);
      tick();
      chk("wr_c1_awvalid", 32'(bus.m_awvalid), 32'b000100);
      chk("wr_c1_wvalid",  32'(bus.m_wvalid),  32'b000100);
      chk("wr_c1_awaddr",  bus.m_awaddr[2*32 +: 32], 32'h0000_0004);
      send_aw_w("wr");
      wait_b("wr");
      chk("wr_bresp",  32'(bus.s_bresp),  32'd0);
      chk("wr_bready", 32'(bus.m_bready), 32'b000100);
      tick();
      chk("wr_bdone",   32'(bus.s_bvalid), 32'd0);
      chk("wr_aw_mask", 32'(aw_mask), 32'b000100);
      chk("wr_wdata",   wcap[2], 32'hA5A5_A5A5);
      chk("wr_wstrb",   32'(scap[2]), 32'hF);
      chk("wr_awaddr",  acap[2], 32'h0000_0004);
      chk("wr_b_cnt",   32'(b_cnt), 32'd1);

      // W three cycles ahead of AW, GPIO slot 1
      clr_mon();
      bus.s_wdata = 32'h1234_5678; bus.s_wvalid = 1'b1;
      early_wready = 1'b0;
      early_wvalid = '0;
      for (int k = 0; k < 3; k++) begin
         tick();
         early_wready = early_wready | bus.s_wready;
         early_wvalid = early_wvalid | bus.m_wvalid;
      end
      chk("wfirst_early_wready", 32'(early_wready), 32'd0);
      chk("wfirst_early_mwvalid", 32'(early_wvalid), 32'd0);
      bus.s_awaddr = 32'h1000_0010; bus.s_awvalid = 1'b1;
      send_aw_w("wfirst");
      wait_b("wfirst");
      chk("wfirst_bresp", 32'(bus.s_bresp), 32'd0);
      tick();
      tick();
      tick();
      chk("wfirst_b_cnt",   32'(b_cnt), 32'd1);
      chk("wfirst_aw_mask", 32'(aw_mask), 32'b000010);
      chk("wfirst_awaddr",  acap[1], 32'h0000_0010);
      chk("wfirst_wdata",   wcap[1], 32'h1234_5678);

      // Unmapped read
      clr_mon();
      bus.s_araddr = 32'h9000_0000; bus.s_arvalid = 1'b1; bus.s_rready = 1'b0;
      #1;
      chk("rmiss_c0_arready", 32'(bus.s_arready), 32'd0);
      tick();
      chk("rmiss_c1_arready", 32'(bus.s_arready), 32'd1);
      tick();
      bus.s_arvalid = 1'b0;
      chk("rmiss_rvalid", 32'(bus.s_rvalid), 32'd1);
      chk("rmiss_rdata",  bus.s_rdata, 32'd0);
      chk("rmiss_rresp",  32'(bus.s_rresp), 32'd3);
      bus.s_rready = 1'b1;
      tick();
      chk("rmiss_rdone",   32'(bus.s_rvalid), 32'd0);
      chk("rmiss_r_cnt",   32'(r_cnt), 32'd1);
      chk("rmiss_ar_mask", 32'(ar_mask), 32'd0);

      // Concurrent slow RAM read and TIMER write
      clr_mon();
      fork
         do_write(32'h5000_0008, 32'h0BAD_F00D, 2'b00, "cw");
         do_read(32'h0000_0100, "cr");
      join
      tick();
      chk("conc_b_before_r", 32'(b_t < r_t), 32'd1);
      chk("conc_rdata",      r_data_cap, 32'hD000_0100);
      chk("conc_rresp",      32'(r_resp_cap), 32'd0);
      chk("conc_aw_mask",    32'(aw_mask), 32'b100000);
      chk("conc_ar_mask",    32'(ar_mask), 32'b000001);
      chk("conc_awaddr",     acap[5], 32'h0000_0008);
      chk("conc_wdata",      wcap[5], 32'h0BAD_F00D);

      // Rogue B on slot 4 while a GPIO write is in flight
      clr_mon();
      rogue_b = 6'b010000;
      bus.s_bready = 1'b1;
      #1;
      chk("rogue_idle_bvalid", 32'(bus.s_bvalid), 32'd0);
      bus.s_awaddr = 32'h1000_0000; bus.s_awvalid = 1'b1;
      bus.s_wdata = 32'h5555_AAAA; bus.s_wvalid = 1'b1;
      send_aw_w("rogue");
      chk("rogue_resp_bvalid", 32'(bus.s_bvalid), 32'd0);
      chk("rogue_bready4",     32'(bus.m_bready[4]), 32'd0);
      chk("rogue_bready",      32'(bus.m_bready), 32'b000010);
      wait_b("rogue");
      chk("rogue_bresp", 32'(bus.s_bresp), 32'd0);
      tick();
      chk("rogue_b_cnt", 32'(b_cnt), 32'd1);
      rogue_b = '0;

      // Unmapped write
      clr_mon();
      do_write(32'h9000_0000, 32'hDEAD_BEEF, 2'b11, "wmiss");
      chk("wmiss_aw_mask", 32'(aw_mask), 32'd0);

      // Reset while B is pending, then a clean SPI write
      bus.s_bready = 1'b0;
      bus.s_awaddr = 32'h1000_0020; bus.s_awvalid = 1'b1;
      bus.s_wdata = 32'h7777_0000; bus.s_wvalid = 1'b1;
      send_aw_w("rstmid");
      wait_b("rstmid");
      resetn = 1'b0;
      #1;
      chk_quiet("rstmid");
      tick();
      resetn = 1'b1;
      tick();
      clr_mon();
      do_write(32'h3000_0000, 32'hCAFE_F00D, 2'b00, "post");
      chk("post_aw_mask", 32'(aw_mask), 32'b001000);
      chk("post_awaddr",  acap[3], 32'h0000_0000);
      chk("post_wdata",   wcap[3], 32'hCAFE_F00D);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/axil_demux_n.md
# axil_demux_n

Parametrised 1-to-N AXI4-Lite demultiplexer that replaces the fixed six-slave SoC interconnect between the PicoRV32 AXI adapter and the memory/peripheral slaves. Address decoding is driven by per-slave BASE/MASK parameters, and the selected slave is registered once per transaction. Each direction runs its own FSM with one outstanding transaction. Unmapped addresses complete locally with DECERR instead of hanging the bus.

## Interface
- `N_SLV`, default 6: number of slave ports (1..16).
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width; strobe width is `DATA_W/8`.
- `BASE`, default `{32'h5000_0000, 32'h4000_0000, 32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0}`: packed `N_SLV*ADDR_W`; slot i holds slave i's base.
- `MASK`, default all `32'hFFFF_F000`: packed `N_SLV*ADDR_W`; slave i hits when `(addr & MASK_i) == BASE_i`.
- `clk`, in, 1: clock.
- `resetn`, in, 1: reset, asynchronous, active-low.
- `s_aw{addr,valid,ready}`, `s_w{data,strb,valid,ready}`, `s_b{resp,valid,ready}`, `s_ar{addr,valid,ready}`, `s_r{data,resp,valid,ready}`: upstream AXI4-Lite port (ADDR_W/DATA_W/2-bit resp).
- `m_*`: the same signal set per slave, flattened to `N_SLV*width` (slot i = slave i). `m_awaddr` and `m_araddr` carry `addr & ~MASK_i`.

## Operation
- Decode: slave i hits on `(addr & MASK_i) == BASE_i`. If several slaves hit, the lowest index wins. If none hits, the transaction is a miss.
- Write FSM states:
  - `W_IDLE`: `s_awready=0`, `s_wready=0`. On `s_awvalid`, register `wsel` (one-hot) and `wmiss`, then go to `W_FWD`.
  - `W_FWD`, hit: `m_awvalid[wsel]=s_awvalid & !aw_done` and `m_wvalid[wsel]=s_wvalid & !w_done`. `s_awready` and `s_wready` are muxed from slave `wsel`. Flags `aw_done` and `w_done` set on their handshakes, in either order or in the same cycle. Go to `W_RESP` when both are done.
  - `W_FWD`, miss: `s_awready=1` and `s_wready=1` internally, gated by the done flags. When both are done, go to `W_ERR`.
  - `W_RESP`: `s_bvalid`/`s_bresp` come from slave `wsel`. `m_bready` equals `s_bready` on slot `wsel` only, 0 elsewhere. On the B handshake, go to `W_IDLE` and clear both flags.
  - `W_ERR`: `s_bvalid=1`, `s_bresp=2'b11`. Go to `W_IDLE` on `s_bready`.
- Read FSM states: `R_IDLE`, then `R_FWD` (forward AR to `rsel`), then `R_DATA` (mux R from `rsel`, `m_rready` only on `rsel`), or `R_ERR` (`s_rvalid=1`, `s_rdata=0`, `s_rresp=2'b11`).
- Read and write FSMs are fully independent. A read and a write to the same slave may overlap.
- Responses from unselected slaves are ignored: `bready`/`rready` stay 0 on those slots, and their valids never reach `s_*`.
- `wdata`, `wstrb` and addresses fan out unconditionally to all slots; only the valids are gated.

## Timing
- Reset (async assert, sync release):
  - FSMs in `IDLE`; `wsel`, `rsel`, flags, `wmiss`, `rmiss` cleared.
  - All `m_*valid`, `m_*ready`, `s_*ready`, `s_bvalid`, `s_rvalid` = 0.
  - `s_bresp`, `s_rresp`, `s_rdata` = 0.
- Latency: `s_awvalid` (or `s_arvalid`) sampled in cycle 0; the `m_` valid is asserted in cycle 1. From cycle 1, the AW/W/AR/B/R paths are combinational pass-through, with zero added latency.
- Miss:
  - AW/W accepted no earlier than cycle 1.
  - `s_bvalid` in the cycle after both are done.
  - `s_rvalid` in the cycle after AR is accepted.
- Back-to-back: after a B or R handshake in cycle t, the FSM is in `IDLE` at t+1, so the next forward is at t+2 at the earliest. Peak rate is one transaction per 3 cycles per direction.
- The upstream must hold `addr` stable while valid (AXI rule), so the registered select remains coherent with the forwarded address.
- A W beat arriving before AW waits in `W_IDLE`; `s_wready` stays 0.
- Reset mid-transaction: everything returns to reset values immediately. Slave-side recovery is the system's responsibility.

## Structure
- Package `axil_pkg`:
  - `RESP_OKAY=2'b00`, `RESP_SLVERR=2'b10`, `RESP_DECERR=2'b11`.
  - FSM state enums for the write and read paths.
  - Default SoC memory-map constants (RAM, GPIO, UART, SPI, I2C, TIMER bases and the 4 KiB mask).
- Sub-module `axil_addr_decode`: combinational; parameters `N_SLV`/`ADDR_W`/`BASE`/`MASK`; outputs a one-hot priority `sel` and `miss`. Instantiated once for AW and once for AR.

## Test plan
- Write `0x2000_0004` = `0xA5A5_A5A5`, strobe `4'hF`:
  - only slot 2 sees `awvalid`, with `awaddr=0x004`;
  - `m_awvalid[2]` is first high in cycle 1;
  - `s_bresp=00` relays slot 2's B.
- W before AW: `s_wvalid` 3 cycles before `s_awvalid` to `0x1000_0010`:
  - no `s_wready` before decode;
  - both handshakes complete;
  - exactly one B.
- Read `0x9000_0000` (unmapped): AR accepted, then `s_rvalid` with `s_rdata=0`, `s_rresp=11`; no `m_arvalid` on any slot.
- Concurrent read `0x0000_0100` and write `0x5000_0008`, with the RAM R delayed 10 cycles: the write B completes first; the R arrives correctly; no cross-routing.
- Rogue response: slot 4 asserts `bvalid` while `wsel`=slot 1:
  - `s_bvalid` stays 0;
  - `m_bready[4]=0`;
  - slot 1's B is relayed normally.
- Reset mid-transaction: `resetn` low in `W_RESP` with `s_bvalid` high; all outputs are 0 in the same cycle. After release, a fresh write to `0x3000_0000` completes normally.
